// File: rtl/sseg_mux_decoder.sv
// Two-digit multiplexed seven-segment word decoder. Each input word is debounced and
// decoded; a tens word followed by a ones word forms a frame, and illegal words are counted.
module sseg_mux_decoder #(
  parameter int STABLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] seg_in,
  input  logic       clr_err,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic [6:0] value,
  output logic       frame_valid,
  output logic       err,
  output logic [7:0] err_count
);

  localparam logic [4:0] STABLE_C = 5'(STABLE_CYCLES);

  typedef enum logic [0:0] {HUNT = 1'b0, HAVE_TENS = 1'b1} state_t;

  // Returns {legal, blank, digit} for a g..a segment pattern.
  function automatic logic [5:0] decode_seg(input logic [6:0] seg);
    case (seg)
      7'b0111111: decode_seg = {1'b1, 1'b0, 4'd0};
      7'b0000110: decode_seg = {1'b1, 1'b0, 4'd1};
      7'b1011011: decode_seg = {1'b1, 1'b0, 4'd2};
      7'b1001111: decode_seg = {1'b1, 1'b0, 4'd3};
      7'b1100110: decode_seg = {1'b1, 1'b0, 4'd4};
      7'b1101101: decode_seg = {1'b1, 1'b0, 4'd5};
      7'b1111101: decode_seg = {1'b1, 1'b0, 4'd6};
      7'b0000111: decode_seg = {1'b1, 1'b0, 4'd7};
      7'b1111111: decode_seg = {1'b1, 1'b0, 4'd8};
      7'b1101111: decode_seg = {1'b1, 1'b0, 4'd9};
      7'b0000000: decode_seg = {1'b1, 1'b1, 4'd0};
      default:    decode_seg = {1'b0, 1'b0, 4'd0};
    endcase
  endfunction

  logic [7:0] sample_r;
  logic       sample_vld_r;
  logic [7:0] prev_r;
  logic       prev_vld_r;
  logic [4:0] run_cnt_r;
  state_t     state_r, state_s;
  logic [3:0] pend_r, pend_s;
  logic [3:0] tens_s, ones_s;
  logic [6:0] value_s;
  logic       frame_valid_s, err_s;
  logic       accept_s;
  logic [5:0] dec_s;

  // Input sampling and run-length counting; the count parks at STABLE_C+1 so a run accepts once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample_r     <= 8'h00;
      sample_vld_r <= 1'b0;
      prev_r       <= 8'h00;
      prev_vld_r   <= 1'b0;
      run_cnt_r    <= 5'd0;
    end else begin
      sample_r     <= seg_in;
      sample_vld_r <= 1'b1;
      if (sample_vld_r) begin
        prev_r     <= sample_r;
        prev_vld_r <= 1'b1;
        if (!prev_vld_r || (sample_r != prev_r)) begin
          run_cnt_r <= 5'd1;
        end else if (run_cnt_r <= STABLE_C) begin
          run_cnt_r <= run_cnt_r + 5'd1;
        end else begin
          run_cnt_r <= run_cnt_r;
        end
      end else begin
        run_cnt_r <= run_cnt_r;
      end
    end
  end

  assign accept_s = (run_cnt_r == STABLE_C);
  assign dec_s    = decode_seg(prev_r[6:0]);

  // Frame FSM next-state and next-output logic.
  always_comb begin
    state_s       = state_r;
    pend_s        = pend_r;
    tens_s        = tens;
    ones_s        = ones;
    value_s       = value;
    frame_valid_s = 1'b0;
    err_s         = 1'b0;
    if (accept_s) begin
      if (!dec_s[5]) begin
        err_s   = 1'b1;
        state_s = HUNT;
        pend_s  = 4'd0;
      end else if (dec_s[4]) begin
        state_s = HUNT;
        pend_s  = 4'd0;
      end else if (prev_r[7]) begin
        pend_s  = dec_s[3:0];
        state_s = HAVE_TENS;
      end else begin
        case (state_r)
          HAVE_TENS: begin
            tens_s        = pend_r;
            ones_s        = dec_s[3:0];
            value_s       = {3'd0, pend_r} * 7'd10 + {3'd0, dec_s[3:0]};
            frame_valid_s = 1'b1;
            pend_s        = 4'd0;
            state_s       = HUNT;
          end
          HUNT:    state_s = HUNT;
          default: state_s = HUNT;
        endcase
      end
    end else begin
      state_s = state_r;
    end
  end

  // FSM state, pending tens and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= HUNT;
      pend_r      <= 4'd0;
      tens        <= 4'd0;
      ones        <= 4'd0;
      value       <= 7'd0;
      frame_valid <= 1'b0;
      err         <= 1'b0;
    end else begin
      state_r     <= state_s;
      pend_r      <= pend_s;
      tens        <= tens_s;
      ones        <= ones_s;
      value       <= value_s;
      frame_valid <= frame_valid_s;
      err         <= err_s;
    end
  end

  // Saturating error counter; clear wins over a coincident error pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_count <= 8'd0;
    end else if (clr_err) begin
      err_count <= 8'd0;
    end else if (err && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end else begin
      err_count <= err_count;
    end
  end

endmodule

// File: tb/tb_sseg_mux_decoder.sv
// Randomized scoreboard bench for sseg_mux_decoder: a run-based reference model predicts
// frame/err events with their cycle stamps; a monitor pops and compares them.
module tb_sseg_mux_decoder;
  localparam int S = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] seg_in;
  logic       clr_err;
  logic [3:0] tens, ones;
  logic [6:0] value;
  logic       frame_valid, err;
  logic [7:0] err_count;

  sseg_mux_decoder #(.STABLE_CYCLES(S)) dut (
    .clk(clk), .reset(reset), .seg_in(seg_in), .clr_err(clr_err),
    .tens(tens), .ones(ones), .value(value), .frame_valid(frame_valid),
    .err(err), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;  // 0 frame, 1 err
    int cyc;
    int t;
    int o;
    int v;
    int ec;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  int last_w = -1;
  int run_len = 0;
  int pend = -1;
  int m_errs = 0;
  int hold_t = 0, hold_o = 0, hold_v = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int seg_digit(input logic [6:0] s);
    for (int i = 0; i < 10; i++) if (seg_tab[i] == s) return i;
    return -1;
  endfunction

  // Reference behaviour of one accepted word; results appear at edge c.
  task automatic model_accept(input logic [7:0] w, input int c);
    exp_t x;
    int d;
    d = seg_digit(w[6:0]);
    x.cyc = c; x.t = 0; x.o = 0; x.v = 0; x.ec = 0;
    if (w[6:0] == 7'h00) begin
      pend = -1;
    end else if (d < 0) begin
      x.kind = 1;
      x.ec = (m_errs > 255) ? 255 : m_errs;
      m_errs++;
      pend = -1;
      q.push_back(x);
    end else if (w[7]) begin
      pend = d;
    end else if (pend >= 0) begin
      x.kind = 0; x.t = pend; x.o = d; x.v = pend * 10 + d;
      q.push_back(x);
      pend = -1;
    end
  endtask

  // Word w is sampled at edge c; the S-th identical consecutive sample is accepted.
  task automatic note(input logic [7:0] w, input int c);
    if (int'(w) == last_w) run_len++;
    else begin
      last_w = int'(w);
      run_len = 1;
    end
    if (run_len == S) model_accept(w, c + 2);
  endtask

  task automatic step(input logic [7:0] w, input logic c = 1'b0);
    @(negedge clk);
    seg_in = w;
    clr_err = c;
    note(w, cyc + 1);
    if (c) m_errs = 0;
  endtask

  task automatic hold(input logic [7:0] w, input int n);
    repeat (n) step(w);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_tens"}, int'(tens), 0);
    check({tag, "_ones"}, int'(ones), 0);
    check({tag, "_value"}, int'(value), 0);
    check({tag, "_fv"}, int'(frame_valid), 0);
    check({tag, "_err"}, int'(err), 0);
    check({tag, "_errcnt"}, int'(err_count), 0);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    #1 reset = 1'b1;
    repeat (n) begin
      @(negedge clk);
      check_zero("reset");
    end
    #1 reset = 1'b0;
    last_w = -1; run_len = 0; pend = -1; m_errs = 0;
    hold_t = 0; hold_o = 0; hold_v = 0;
    q.delete();
    note(seg_in, cyc + 1);
  endtask

  // Monitor: pops expected events when the DUT pulses, and checks held outputs.
  always @(negedge clk) begin
    if (!reset) begin
      if (q.size() > 0 && q[0].cyc < cyc) begin
        e = q.pop_front();
        check(e.kind == 0 ? "missing_frame" : "missing_err", cyc, e.cyc);
      end
      if (frame_valid || err) begin
        check("fv_err_exclusive", int'(frame_valid && err), 0);
        if (q.size() == 0) begin
          check("unexpected_event", int'(frame_valid) * 2 + int'(err), 0);
        end else begin
          e = q.pop_front();
          check("event_kind", frame_valid ? 0 : 1, e.kind);
          check("event_cycle", cyc, e.cyc);
          if (e.kind == 0) begin
            hold_t = e.t; hold_o = e.o; hold_v = e.v;
          end else begin
            check("err_count_at_err", int'(err_count), e.ec);
          end
        end
      end
      check("tens_hold", int'(tens), hold_t);
      check("ones_hold", int'(ones), hold_o);
      check("value_hold", int'(value), hold_v);
    end
  end

  initial begin
    reset = 1'b1;
    seg_in = 8'h00;
    clr_err = 1'b0;
    do_reset(3);

    hold(8'h00, 3);
    hold(8'h86, 4); hold(8'h4F, 4); hold(8'h00, 3);
    check("frame13_tens", int'(tens), 1);
    check("frame13_ones", int'(ones), 3);
    check("frame13_value", int'(value), 13);

    hold(8'h86, 1); hold(8'h4F, 4); hold(8'h00, 3);
    hold(8'h86, 3); hold(8'h00, 3); hold(8'h4F, 3); hold(8'h00, 3);
    check("blank_hold_value", int'(value), 13);

    hold(8'hDB, 3); hold(8'hE6, 3); hold(8'h3F, 3); hold(8'h00, 3);
    check("latest_tens_value", int'(value), 40);

    hold(8'hEF, 3); hold(8'h6F, 3); hold(8'h00, 3);
    check("frame99_value", int'(value), 99);
    step(8'hED);
    do_reset(1);
    hold(8'h6F, 3); hold(8'h00, 3);
    check("after_reset_value", int'(value), 0);

    for (int i = 0; i < 300; i++) begin
      hold(8'h81, 3);
      hold(8'h00, 3);
    end
    hold(8'h00, 2);
    check("err_saturated", int'(err_count), 255);
    step(8'h00, 1'b1);
    step(8'h00);
    check("err_cleared", int'(err_count), 0);

    for (int i = 0; i < 500; i++) begin
      int r;
      logic [7:0] w;
      r = $urandom_range(0, 9);
      if (r < 4)       w = {1'b1, seg_tab[$urandom_range(0, 9)]};
      else if (r < 8)  w = {1'b0, seg_tab[$urandom_range(0, 9)]};
      else if (r == 8) w = {1'($urandom_range(0, 1)), 7'h00};
      else             w = 8'($urandom);
      hold(w, $urandom_range(1, 4));
    end
    hold(8'h00, 6);
    check("queue_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL timeout: got running expected finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
